// File: rtl/elock_keypad_seq.sv
`default_nettype none
// ============================================================================
// Module      : elock_keypad_seq
// Description : Keypad front-end and event sequencer for the electronic door
//               lock. Scans a 4x3 keypad, debounces press and release,
//               decodes keys and assembles 4-digit codes. Emits single-cycle
//               arm / unarm / openreq / entry_timeout pulses and a stable
//               keys bus.
//               Optional feature: define ELOCK_SCAN_HOLDOFF_EN to ignore the
//               keypad for HOLDOFF_CYC cycles after every openreq.
// Revision    : 1.0 - initial release
// ============================================================================
module elock_keypad_seq #(
    parameter int SCAN_DIV    = 16,
    parameter int DEB_CYC     = 8,
    parameter int TIMEOUT_CYC = 1000,
    parameter int HOLDOFF_CYC = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [2:0]  col,
    output logic        arm,
    output logic        unarm,
    output logic        openreq,
    output logic [15:0] keys,
    output logic [2:0]  digit_cnt,
    output logic        entry_timeout
);

    localparam int C_SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int C_DEB_W  = $clog2(DEB_CYC + 1);
    localparam int C_TMO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [C_SCAN_W-1:0] C_SCAN_LAST = C_SCAN_W'(SCAN_DIV - 1);
    localparam logic [C_DEB_W-1:0]  C_DEB_LAST  = C_DEB_W'(DEB_CYC - 1);
    localparam logic [C_TMO_W-1:0]  C_TMO_LAST  = C_TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_col;
    logic [C_SCAN_W-1:0] r_scan_cnt;
    logic [3:0]          r_row_cap;
    logic [C_DEB_W-1:0]  r_deb_cnt;
    logic [11:0]         r_shift;
    logic [2:0]          r_digit_cnt;
    logic [15:0]         r_keys;
    logic [C_TMO_W-1:0]  r_idle_cnt;
    logic                r_arm;
    logic                r_unarm;
    logic                r_openreq;
    logic                r_tmo;

    logic                w_hold_active;
    logic                w_row_seen;
    logic                w_emit;
    logic                w_digit_emit;
    logic                w_code_done;
    logic                w_tmo_hit;
    logic [1:0]          w_top_row;
    logic [1:0]          w_row_rank;
    logic [1:0]          w_col_idx;
    logic                w_bottom;
    logic                w_is_hash;
    logic                w_is_star;
    logic [3:0]          w_digit;

`ifdef ELOCK_SCAN_HOLDOFF_EN
    localparam int C_HOLD_W = $clog2(HOLDOFF_CYC + 2);
    logic [C_HOLD_W-1:0] r_hold_cnt;

    // Holdoff window: loaded when a code completes, counts down to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (w_code_done) begin
            r_hold_cnt <= C_HOLD_W'(HOLDOFF_CYC);
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - C_HOLD_W'(1);
        end
    end

    assign w_hold_active = (r_hold_cnt != '0);
`else
    // Holdoff is compiled out; this constant is never true.
    assign w_hold_active = (HOLDOFF_CYC < 0);
`endif

    // A key return is acted upon only while scanning and not held off.
    assign w_row_seen   = (r_state == ST_SCAN) && !w_hold_active && (row != 4'b0000);
    assign w_emit       = (r_state == ST_EMIT);
    assign w_digit_emit = w_emit && !w_is_hash && !w_is_star;
    assign w_code_done  = w_digit_emit && (r_digit_cnt == 3'd3);
    assign w_tmo_hit    = (r_digit_cnt != 3'd0) && !w_hold_active && (r_idle_cnt == C_TMO_LAST);

    // Key decode from the captured row pattern and the frozen column.
    always_comb begin
        w_top_row = 2'd0;
        if (r_row_cap[3]) begin
            w_top_row = 2'd3;
        end else if (r_row_cap[2]) begin
            w_top_row = 2'd2;
        end else if (r_row_cap[1]) begin
            w_top_row = 2'd1;
        end
        w_col_idx = 2'd0;
        if (r_col[1]) begin
            w_col_idx = 2'd1;
        end else if (r_col[0]) begin
            w_col_idx = 2'd2;
        end
        w_bottom   = (w_top_row == 2'd0);
        w_is_hash  = w_bottom && r_col[0];
        w_is_star  = w_bottom && r_col[2];
        w_row_rank = 2'd3 - w_top_row;
        w_digit    = w_bottom ? 4'h0
                              : 4'd1 + ({2'b00, w_row_rank} * 4'd3) + {2'b00, w_col_idx};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; an active holdoff pins the FSM in SCAN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SCAN: begin
                if (w_row_seen) begin
                    w_state_nxt = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (row != r_row_cap) begin
                    w_state_nxt = ST_SCAN;
                end else if (r_deb_cnt == C_DEB_LAST) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if ((row == 4'b0000) && (r_deb_cnt == C_DEB_LAST)) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
        if (w_hold_active) begin
            w_state_nxt = ST_SCAN;
        end
    end

    // Column rotation; the column freezes whenever the FSM leaves SCAN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col      <= 3'b100;
            r_scan_cnt <= '0;
        end else if ((r_state == ST_SCAN) && !w_row_seen) begin
            if (r_scan_cnt == C_SCAN_LAST) begin
                r_col      <= {r_col[0], r_col[2:1]};
                r_scan_cnt <= '0;
            end else begin
                r_scan_cnt <= r_scan_cnt + C_SCAN_W'(1);
            end
        end else begin
            r_scan_cnt <= '0;
        end
    end

    // Capture of the first-sampled row pattern for debounce comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_cap <= 4'b0000;
        end else if (w_row_seen) begin
            r_row_cap <= row;
        end
    end

    // Stable-cycle counter shared by press debounce and release debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_cnt <= '0;
        end else begin
            case (r_state)
                ST_DEBOUNCE: r_deb_cnt <= (row == r_row_cap) ? r_deb_cnt + C_DEB_W'(1) : '0;
                ST_RELEASE:  r_deb_cnt <= (row == 4'b0000)   ? r_deb_cnt + C_DEB_W'(1) : '0;
                default:     r_deb_cnt <= '0;
            endcase
        end
    end

    // Code assembly, event pulses and partial-entry timeout; EMIT outranks timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= 12'h000;
            r_digit_cnt <= 3'd0;
            r_keys      <= 16'h0000;
            r_idle_cnt  <= '0;
            r_arm       <= 1'b0;
            r_unarm     <= 1'b0;
            r_openreq   <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_arm     <= 1'b0;
            r_unarm   <= 1'b0;
            r_openreq <= 1'b0;
            r_tmo     <= 1'b0;
            if (w_emit && (w_is_hash || w_is_star)) begin
                r_arm       <= w_is_hash;
                r_unarm     <= w_is_star;
                r_shift     <= 12'h000;
                r_digit_cnt <= 3'd0;
                r_idle_cnt  <= '0;
            end else if (w_digit_emit) begin
                r_idle_cnt <= '0;
                if (r_digit_cnt == 3'd3) begin
                    r_keys      <= {r_shift, w_digit};
                    r_openreq   <= 1'b1;
                    r_shift     <= 12'h000;
                    r_digit_cnt <= 3'd0;
                end else begin
                    r_shift     <= {r_shift[7:0], w_digit};
                    r_digit_cnt <= r_digit_cnt + 3'd1;
                end
            end else if (w_tmo_hit) begin
                r_tmo       <= 1'b1;
                r_shift     <= 12'h000;
                r_digit_cnt <= 3'd0;
                r_idle_cnt  <= '0;
            end else if (r_digit_cnt == 3'd0) begin
                r_idle_cnt <= '0;
            end else if (!w_hold_active) begin
                r_idle_cnt <= r_idle_cnt + C_TMO_W'(1);
            end
        end
    end

    assign col           = r_col;
    assign arm           = r_arm;
    assign unarm         = r_unarm;
    assign openreq       = r_openreq;
    assign keys          = r_keys;
    assign digit_cnt     = r_digit_cnt;
    assign entry_timeout = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_elock_keypad_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_elock_keypad_seq
// Description : Self-checking bench for elock_keypad_seq. A keypad model
//               returns rows from the driven column; a scoreboard holds the
//               expected output events pushed as keys are pressed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elock_keypad_seq;

    localparam int SCAN_DIV    = 4;
    localparam int DEB_CYC     = 3;
    localparam int TIMEOUT_CYC = 50;
    localparam int HOLDOFF_CYC = 20;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [2:0]  col;
    logic        arm;
    logic        unarm;
    logic        openreq;
    logic [15:0] keys;
    logic [2:0]  digit_cnt;
    logic        entry_timeout;

    logic        key_on;
    logic [1:0]  key_r;
    logic [1:0]  key_c;

    int          vectors;
    int          miscompares;
    int          cyc;
    int          last_rec_cyc;
    logic [2:0]  prev_cnt;
    logic [22:0] sb[$];

    logic [15:0] m_keys;
    logic [15:0] m_shift;
    logic [2:0]  m_cnt;

    elock_keypad_seq #(
        .SCAN_DIV    (SCAN_DIV),
        .DEB_CYC     (DEB_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .HOLDOFF_CYC (HOLDOFF_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .row           (row),
        .col           (col),
        .arm           (arm),
        .unarm         (unarm),
        .openreq       (openreq),
        .keys          (keys),
        .digit_cnt     (digit_cnt),
        .entry_timeout (entry_timeout)
    );

    // Keypad: the pressed key connects its row to its column line.
    assign row = (key_on && col[key_c]) ? (4'b0001 << key_r) : 4'b0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [22:0] rec(input logic a, input logic u, input logic o,
                                        input logic t, input logic [15:0] k,
                                        input logic [2:0] c);
        return {a, u, o, t, k, c};
    endfunction

    // Output monitor: one record per event, compared against the scoreboard.
    always @(negedge clk) begin
        logic [22:0] obs;
        logic [22:0] expv;
        cyc = cyc + 1;
        if (rst) begin
            prev_cnt = digit_cnt;
        end else if (arm || unarm || openreq || entry_timeout || (digit_cnt != prev_cnt)) begin
            obs          = rec(arm, unarm, openreq, entry_timeout, keys, digit_cnt);
            last_rec_cyc = cyc;
            vectors      = vectors + 1;
            if (sb.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL event: got {a,u,o,t,keys,cnt}=%h, required no event", obs);
            end else begin
                expv = sb.pop_front();
                if (obs !== expv) begin
                    miscompares = miscompares + 1;
                    $display("FAIL event: got {a,u,o,t,keys,cnt}=%h, required %h", obs, expv);
                end
            end
            prev_cnt = digit_cnt;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model of one key press: pushes the event the press must cause.
    task automatic exp_key(input int rb, input int cb);
        logic [3:0] d;
        if (rb == 0 && cb == 0) begin
            m_cnt = 3'd0; m_shift = 16'h0;
            sb.push_back(rec(1'b1, 1'b0, 1'b0, 1'b0, m_keys, 3'd0));
        end else if (rb == 0 && cb == 2) begin
            m_cnt = 3'd0; m_shift = 16'h0;
            sb.push_back(rec(1'b0, 1'b1, 1'b0, 1'b0, m_keys, 3'd0));
        end else begin
            d = (rb == 0) ? 4'd0 : 4'(1 + 3 * (3 - rb) + (2 - cb));
            if (m_cnt < 3'd3) begin
                m_shift = {m_shift[11:0], d};
                m_cnt   = m_cnt + 3'd1;
                sb.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, m_keys, m_cnt));
            end else begin
                m_keys  = {m_shift[11:0], d};
                m_shift = 16'h0;
                m_cnt   = 3'd0;
                sb.push_back(rec(1'b0, 1'b0, 1'b1, 1'b0, m_keys, 3'd0));
            end
        end
    endtask

    task automatic press_key(input int rb, input int cb, input int hold_after);
        int n;
        exp_key(rb, cb);
        key_r = 2'(rb); key_c = 2'(cb); key_on = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 60) begin tick(); n++; end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL press_r%0d_c%0d: %0d events pending after %0d cycles, required 0",
                     rb, cb, sb.size(), n);
            sb.delete();
        end
        repeat (hold_after) tick();
        key_on = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if (col !== 3'b100) begin miscompares++; $display("FAIL reset_col: got %b required 100", col); end
        vectors++;
        if ({arm, unarm, openreq, entry_timeout} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_pulses: got %b required 0000", {arm, unarm, openreq, entry_timeout});
        end
        vectors++;
        if (keys !== 16'h0000) begin miscompares++; $display("FAIL reset_keys: got %h required 0000", keys); end
        vectors++;
        if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d required 0", digit_cnt); end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_code_entry();
        press_key(3, 2, 5);
        press_key(3, 2, 5);
        press_key(2, 1, 5);
        press_key(2, 1, 5);
        vectors++;
        if (keys !== 16'h1155) begin miscompares++; $display("FAIL code_1155: got %h required 1155", keys); end
    endtask

    task automatic test_arm_unarm();
        press_key(1, 2, 5);
        press_key(0, 0, 5);
        press_key(0, 2, 5);
        vectors++;
        if (keys !== 16'h1155) begin miscompares++; $display("FAIL arm_keys_kept: got %h required 1155", keys); end
    endtask

    task automatic test_bounce();
        int n;
        n = 0;
        while (col[2] !== 1'b1 && n < 40) begin tick(); n++; end
        exp_key(3, 2);
        key_r = 2'd3; key_c = 2'd2; key_on = 1'b1;
        tick();
        key_on = 1'b0;
        tick();
        key_on = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 60) begin tick(); n++; end
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL bounce_clean: %0d pending, required 0", sb.size()); sb.delete(); end
        repeat (5) tick();
        key_on = 1'b0;
        repeat (10) tick();
        // Row changes from row[3] to row[2] on the same column mid-debounce.
        n = 0;
        while (col[2] !== 1'b1 && n < 40) begin tick(); n++; end
        exp_key(2, 2);
        key_r = 2'd3; key_c = 2'd2; key_on = 1'b1;
        repeat (2) tick();
        key_r = 2'd2;
        n = 0;
        while (sb.size() != 0 && n < 60) begin tick(); n++; end
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL bounce_switch: %0d pending, required 0", sb.size()); sb.delete(); end
        repeat (5) tick();
        key_on = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_timeout();
        int n;
        int t0;
        t0 = last_rec_cyc;
        m_cnt = 3'd0; m_shift = 16'h0;
        sb.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, m_keys, 3'd0));
        n = 0;
        while (sb.size() != 0 && n < 80) begin tick(); n++; end
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL timeout_seen: %0d pending, required 0", sb.size()); sb.delete(); end
        vectors++;
        if (last_rec_cyc - t0 != TIMEOUT_CYC) begin
            miscompares++; $display("FAIL timeout_delay: got %0d cycles required %0d", last_rec_cyc - t0, TIMEOUT_CYC);
        end
        repeat (5) tick();
        press_key(0, 1, 5);
        press_key(0, 1, 5);
        press_key(0, 1, 5);
        press_key(0, 1, 5);
        vectors++;
        if (keys !== 16'h0000) begin miscompares++; $display("FAIL code_0000: got %h required 0000", keys); end
    endtask

    task automatic test_latency();
        int n;
        int lat;
        repeat (30) tick();
        n = 0;
        while (col !== 3'b100 && n < 40) begin tick(); n++; end
        exp_key(3, 2);
        key_r = 2'd3; key_c = 2'd2; key_on = 1'b1;
        lat = 0;
        while (sb.size() != 0 && lat < 40) begin tick(); lat++; end
        vectors++;
        if (lat - 1 != DEB_CYC + 1) begin
            miscompares++; $display("FAIL latency: got event at t+%0d required t+%0d", lat - 1, DEB_CYC + 1);
            sb.delete();
        end
        repeat (5) tick();
        key_on = 1'b0;
        repeat (10) tick();
        press_key(3, 1, 5);
        press_key(3, 0, 5);
        press_key(2, 2, 5);
        vectors++;
        if (keys !== 16'h1234) begin miscompares++; $display("FAIL code_1234: got %h required 1234", keys); end
    endtask

    task automatic test_hold_reset();
        int n;
        repeat (30) tick();
        exp_key(1, 0);
        key_r = 2'd1; key_c = 2'd0; key_on = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 60) begin tick(); n++; end
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL hold9_seen: %0d pending, required 0", sb.size()); sb.delete(); end
        repeat (40) tick();
        rst = 1'b1;
        tick();
        m_keys = 16'h0; m_shift = 16'h0; m_cnt = 3'd0;
        vectors++;
        if (col !== 3'b100) begin miscompares++; $display("FAIL midreset_col: got %b required 100", col); end
        vectors++;
        if (keys !== 16'h0000) begin miscompares++; $display("FAIL midreset_keys: got %h required 0000", keys); end
        vectors++;
        if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL midreset_cnt: got %0d required 0", digit_cnt); end
        vectors++;
        if ({arm, unarm, openreq, entry_timeout} !== 4'b0000) begin
            miscompares++; $display("FAIL midreset_pulses: got %b required 0000", {arm, unarm, openreq, entry_timeout});
        end
        rst = 1'b0;
        key_on = 1'b0;
        repeat (10) tick();
    endtask

`ifdef ELOCK_SCAN_HOLDOFF_EN
    task automatic test_holdoff();
        int n;
        press_key(3, 2, 5);
        press_key(3, 1, 5);
        press_key(3, 0, 5);
        exp_key(2, 2);
        key_r = 2'd2; key_c = 2'd2; key_on = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 60) begin tick(); n++; end
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL holdoff_openreq: %0d pending, required 0", sb.size()); sb.delete(); end
        key_on = 1'b0;
        repeat (4) tick();
        key_r = 2'd3; key_c = 2'd2; key_on = 1'b1;
        repeat (7) tick();
        key_on = 1'b0;
        repeat (13) tick();
        vectors++;
        if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL holdoff_ignore: got cnt %0d required 0", digit_cnt); end
        press_key(3, 2, 5);
    endtask
`endif

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; last_rec_cyc = 0;
        prev_cnt = 3'd0;
        m_keys = 16'h0; m_shift = 16'h0; m_cnt = 3'd0;
        key_on = 1'b0; key_r = 2'd0; key_c = 2'd0;
        rst = 1'b1;
        test_reset();
        test_code_entry();
        test_arm_unarm();
        test_bounce();
        test_timeout();
        test_latency();
        test_hold_reset();
`ifdef ELOCK_SCAN_HOLDOFF_EN
        test_holdoff();
`endif
        repeat (5) tick();
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL final_drain: %0d pending, required 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
